mem_cycle_seq: RTL and testbench



---
 rtl/eclair_bus_pkg.sv | 13 +
 rtl/mem_wait_timer.sv | 17 +
 rtl/mem_cycle_seq.sv | 109 ++++++++++
 tb/tb_mem_cycle_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/eclair_bus_pkg.sv
// eclair_bus_pkg: shared state encoding, byte indices and timing defaults for the memory bus sequencer
package eclair_bus_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;
    localparam logic BYTE_LO = 1'b0;
    localparam logic BYTE_HI = 1'b1;
    localparam int unsigned DEFAULT_WAIT_STATES = 1;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: loadable down-counter whose zero flag marks the last strobe cycle
module mem_wait_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       zero
);
    logic [2:0] cnt;
    // reload on demand, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != 3'd0) cnt <= cnt - 3'd1;
    end
    assign zero = cnt == 3'd0;
endmodule

// File: rtl/mem_cycle_seq.sv
// mem_cycle_seq: turns one microcode memory request into one or two byte-wide bus cycles
module mem_cycle_seq
    import eclair_bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES,
    parameter int unsigned ADDR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_read,
    input  logic                  start_write,
    input  logic                  op_16bit,
    input  logic [ADDR_WIDTH-1:0] mar,
    input  logic [15:0]           wdata,
    input  logic [7:0]            bus_data_in,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_data_out,
    output logic                  bus_data_oe,
    output logic                  _w,
    output logic                  _rd,
    output logic [15:0]           rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    if (WAIT_STATES > 7) begin : g_ws_range
        $error("mem_cycle_seq: WAIT_STATES must be in 0..7");
    end

    state_t     state, state_nx;
    logic       is_write, is_16, idx, accept, more, wt_zero;
    logic [7:0] wdata_hi;

    assign accept = state == S_IDLE && (start_read ^ start_write);
    assign more   = is_16 && idx == BYTE_LO;

    mem_wait_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == S_SETUP),
        .load_val (3'(WAIT_STATES)),
        .zero     (wt_zero)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else state <= state_nx;
    end

    // next state and strobe/status decode; strobes are only ever low in STROBE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = accept ? S_SETUP : S_IDLE;
            S_SETUP:  state_nx = S_STROBE;
            S_STROBE: state_nx = wt_zero ? S_HOLD : S_STROBE;
            S_HOLD:   state_nx = more ? S_SETUP : S_DONE;
            default:  state_nx = S_IDLE;
        endcase
        _w   = !(state == S_STROBE && is_write);
        _rd  = !(state == S_STROBE && !is_write);
        busy = state != S_IDLE;
        done = state == S_DONE;
    end

    // request latching, address/data sequencing and read-byte capture
    always_ff @(posedge clk) begin
        if (reset) begin
            is_write     <= 1'b0;
            is_16        <= 1'b0;
            idx          <= BYTE_LO;
            wdata_hi     <= '0;
            bus_addr     <= '0;
            bus_data_out <= '0;
            bus_data_oe  <= 1'b0;
            rdata        <= '0;
            err          <= 1'b0;
        end else begin
            err <= state == S_IDLE && start_read && start_write;
            if (accept) begin
                is_write <= start_write;
                is_16    <= op_16bit;
                idx      <= BYTE_LO;
                wdata_hi <= wdata[15:8];
                bus_addr <= mar;
                if (start_write) begin
                    bus_data_out <= wdata[7:0];
                    bus_data_oe  <= 1'b1;
                end else begin
                    rdata <= '0;
                end
            end
            if (state == S_STROBE && wt_zero && !is_write) begin
                if (idx) rdata[15:8] <= bus_data_in;
                else rdata[7:0] <= bus_data_in;
            end
            if (state == S_HOLD) begin
                if (more) begin
                    idx      <= BYTE_HI;
                    bus_addr <= bus_addr + ADDR_WIDTH'(1);
                    if (is_write) bus_data_out <= wdata_hi;
                end else begin
                    bus_data_oe <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_cycle_seq.sv
// tb_mem_cycle_seq: scoreboard bench for the memory bus cycle sequencer
module tb_mem_cycle_seq;
    localparam int WS = 1;

    typedef struct {
        int rdata;
        int lat;
        int nw;
        int nr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_read = 1'b0, start_write = 1'b0, op_16bit = 1'b0;
    logic [15:0] mar = '0, wdata = '0;
    logic [7:0]  bus_data_in, bus_data_out;
    logic [15:0] bus_addr, rdata;
    logic        bus_data_oe, w_n, rd_n, busy, done, err;

    logic        start_read0 = 1'b0;
    logic [7:0]  bus_data_in0, bus_data_out0;
    logic [15:0] bus_addr0, rdata0;
    logic        bus_data_oe0, w_n0, rd_n0, busy0, done0, err0;

    logic [7:0] mem [0:65535];
    int checks = 0, errors = 0;
    exp_t q[$];
    exp_t q0[$];
    int cyc = 0, t0 = 0, nw = 0, nr = 0, bad_strobe = 0, err_seen = 0;
    logic busy_q = 1'b0;
    int t0_0 = 0, last_done0 = 0;
    logic busy0_q = 1'b0, have_done0 = 1'b0;
    int wrun = 0;

    always #5 clk = ~clk;

    assign bus_data_in  = mem[bus_addr];
    assign bus_data_in0 = mem[bus_addr0];

    mem_cycle_seq #(.WAIT_STATES(WS), .ADDR_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start_read(start_read), .start_write(start_write),
        .op_16bit(op_16bit), .mar(mar), .wdata(wdata), .bus_data_in(bus_data_in),
        .bus_addr(bus_addr), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
        ._w(w_n), ._rd(rd_n), .rdata(rdata), .busy(busy), .done(done), .err(err)
    );

    mem_cycle_seq #(.WAIT_STATES(0), .ADDR_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .start_read(start_read0), .start_write(1'b0),
        .op_16bit(1'b0), .mar(16'h2000), .wdata(16'h0000), .bus_data_in(bus_data_in0),
        .bus_addr(bus_addr0), .bus_data_out(bus_data_out0), .bus_data_oe(bus_data_oe0),
        ._w(w_n0), ._rd(rd_n0), .rdata(rdata0), .busy(busy0), .done(done0), .err(err0)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // memory commits a byte only after a full-width write pulse
    always @(negedge clk) begin
        if (!w_n) begin
            wrun++;
            if (wrun == WS + 1) mem[bus_addr] = bus_data_out;
        end else begin
            wrun = 0;
        end
    end

    // monitor for the main instance: pops an expectation on every done
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (busy && !busy_q) begin
            t0 = cyc;
            nw = 0;
            nr = 0;
        end
        if (!w_n) nw++;
        if (!rd_n) nr++;
        if (!w_n && !rd_n) bad_strobe++;
        if (!w_n && !bus_data_oe) bad_strobe++;
        if (err) err_seen++;
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = q.pop_front();
                check("rdata", int'(rdata), e.rdata);
                check("latency", cyc - t0 + 1, e.lat);
                check("w_low_cycles", nw, e.nw);
                check("rd_low_cycles", nr, e.nr);
            end
        end
        busy_q = busy;
    end

    // monitor for the zero-wait instance: latency and idle gap between back-to-back reads
    always @(negedge clk) begin
        exp_t e;
        if (busy0 && !busy0_q) begin
            t0_0 = cyc;
            if (have_done0) check("b2b_idle_gap", cyc - last_done0 - 1, 1);
        end
        if (done0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done0: got done with empty scoreboard, expected none");
            end else begin
                e = q0.pop_front();
                check("b2b_rdata", int'(rdata0), e.rdata);
                check("b2b_latency", cyc - t0_0 + 1, e.lat);
            end
            last_done0 = cyc;
            have_done0 = 1'b1;
        end
        busy0_q = busy0;
    end

    task automatic issue(input logic rd, input logic wr, input logic b16,
                         input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        start_read = rd;
        start_write = wr;
        op_16bit = b16;
        mar = a;
        wdata = d;
        @(negedge clk);
        start_read = 1'b0;
        start_write = 1'b0;
        op_16bit = 1'($urandom);
        mar = 16'($urandom);
        wdata = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL timeout: busy still 1 after 40 cycles, expected 0");
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h2000] = 8'h34;
        mem[16'h2001] = 8'h12;
        repeat (3) @(negedge clk);
        check("rst_addr_data_oe", {bus_addr, bus_data_out, 7'd0, bus_data_oe}, 0);
        check("rst_w_rd_rdata", {w_n, rd_n, rdata}, {2'b11, 16'h0000});
        check("rst_busy_done_err", {busy, done, err}, 0);
        reset = 1'b0;

        q.push_back('{rdata: 0, lat: WS + 4, nw: WS + 1, nr: 0});
        issue(1'b0, 1'b1, 1'b0, 16'h1234, 16'h00AB);
        wait_idle();
        check("wr8_mem_1234", int'(mem[16'h1234]), 8'hAB);

        q.push_back('{rdata: 16'h1234, lat: 2 * (WS + 3) + 1, nw: 0, nr: 2 * (WS + 1)});
        issue(1'b1, 1'b0, 1'b1, 16'h2000, 16'h0000);
        wait_idle();

        q.push_back('{rdata: 16'h1234, lat: 2 * (WS + 3) + 1, nw: 2 * (WS + 1), nr: 0});
        issue(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
        wait_idle();
        check("wr16_mem_ffff", int'(mem[16'hFFFF]), 8'hEF);
        check("wr16_mem_0000_wrap", int'(mem[16'h0000]), 8'hBE);
        check("no_err_before_illegal", err_seen, 0);

        @(negedge clk);
        start_read = 1'b1;
        start_write = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        start_write = 1'b0;
        check("illegal_err_pulse", {err, busy, w_n, rd_n}, 4'b1011);
        @(negedge clk);
        check("illegal_err_one_cycle", {err, busy}, 0);

        q.push_back('{rdata: 16'h0012, lat: WS + 4, nw: 0, nr: WS + 1});
        issue(1'b1, 1'b0, 1'b0, 16'h2001, 16'h0000);
        wait_idle();

        issue(1'b0, 1'b1, 1'b1, 16'h3000, 16'h5A6B);
        repeat (5) @(negedge clk);
        check("second_byte_strobe_low", {w_n, 15'd0, bus_addr}, 16'h3001);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_w_busy_done", {w_n, busy, done}, 3'b100);
        check("midrst_rdata", int'(rdata), 0);
        reset = 1'b0;
        check("midrst_first_byte", int'(mem[16'h3000]), 8'h6B);
        check("midrst_second_byte", int'(mem[16'h3001]), 8'h00);

        repeat (3) q0.push_back('{rdata: 16'h0034, lat: 4, nw: 0, nr: 0});
        @(negedge clk);
        start_read0 = 1'b1;
        repeat (12) @(negedge clk);
        start_read0 = 1'b0;
        repeat (10) @(negedge clk);

        check("err_pulses_total", err_seen, 1);
        check("strobe_rules", bad_strobe, 0);
        check("scoreboard_drained", q.size(), 0);
        check("scoreboard0_drained", q0.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
